// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and ex_hazard_ctrl.
// Decode/execute status flows in, stall/flush/freeze controls flow out.
interface ex_hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic        id_rs_valid;
    logic [2:0]  id_rt;
    logic        id_rt_valid;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [2:0]  ex_rd;
    logic        branch;
    logic        ex_halt;
    logic        mem_busy;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs, id_rs_valid, id_rt, id_rt_valid,
        output ex_valid, ex_mem_read, ex_rd,
        output branch, ex_halt, mem_busy,
        input  pc_stall, ifid_stall, ifid_flush,
        input  idex_bubble, pipe_freeze, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rs_valid, id_rt, id_rt_valid,
        input  ex_valid, ex_mem_read, ex_rd,
        input  branch, ex_halt, mem_busy,
        output pc_stall, ifid_stall, ifid_flush,
        output idex_bubble, pipe_freeze, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use bubbles, branch flushes,
// memory-busy freezes and HALT, with saturating stall/flush counters.
module ex_hazard_ctrl (
    input  logic             clk,
    input  logic             rst,
    ex_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        rs_hit;
    logic        rt_hit;
    logic        hazard;
    logic        br_taken;
    logic        halt_req;

    logic        ev_busy;
    logic        ev_branch;
    logic        ev_halt;
    logic        ev_hazard;
    logic        ev_none;

    logic        stall_inc;
    logic        flush_inc;
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // R0 is an ordinary register here: no zero-register exemption.
    assign rs_hit   = bus.id_rs_valid & (bus.id_rs == bus.ex_rd);
    assign rt_hit   = bus.id_rt_valid & (bus.id_rt == bus.ex_rd);
    assign hazard   = bus.ex_valid & bus.ex_mem_read & (rs_hit | rt_hit);
    assign br_taken = bus.ex_valid & bus.branch;
    assign halt_req = bus.ex_valid & bus.ex_halt;

    // One-hot RUN-state events, already priority-resolved.
    assign ev_busy   = bus.mem_busy;
    assign ev_branch = ~bus.mem_busy & br_taken;
    assign ev_halt   = ~bus.mem_busy & ~br_taken & halt_req;
    assign ev_hazard = ~bus.mem_busy & ~br_taken & ~halt_req & hazard;
    assign ev_none   = ~(ev_busy | ev_branch | ev_halt | ev_hazard);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                unique case (1'b1)
                    ev_busy:   state_d = RUN;
                    ev_branch: state_d = RUN;
                    ev_halt:   state_d = HALTED;
                    ev_hazard: state_d = LU_BUBBLE;
                    ev_none:   state_d = RUN;
                endcase
            end
            LU_BUBBLE: begin
                state_d = bus.mem_busy ? LU_BUBBLE : RUN;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Mealy control outputs; reset blanks every output immediately.
    always_comb begin
        bus.pc_stall    = 1'b0;
        bus.ifid_stall  = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.pipe_freeze = 1'b0;
        bus.halted      = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    unique case (1'b1)
                        ev_busy: begin
                            bus.pc_stall    = 1'b1;
                            bus.ifid_stall  = 1'b1;
                            bus.pipe_freeze = 1'b1;
                            stall_inc       = 1'b1;
                        end
                        ev_branch: begin
                            bus.ifid_flush  = 1'b1;
                            bus.idex_bubble = 1'b1;
                            flush_inc       = 1'b1;
                        end
                        ev_halt: begin
                            bus.pc_stall    = 1'b1;
                            bus.ifid_stall  = 1'b1;
                            bus.idex_bubble = 1'b1;
                        end
                        ev_hazard: begin
                            bus.pc_stall    = 1'b1;
                            bus.ifid_stall  = 1'b1;
                            bus.idex_bubble = 1'b1;
                            stall_inc       = 1'b1;
                        end
                        ev_none: begin
                            bus.pc_stall    = 1'b0;
                        end
                    endcase
                end
                LU_BUBBLE: begin
                    if (bus.mem_busy) begin
                        bus.pc_stall    = 1'b1;
                        bus.ifid_stall  = 1'b1;
                        bus.pipe_freeze = 1'b1;
                        stall_inc       = 1'b1;
                    end
                end
                HALTED: begin
                    bus.pc_stall    = 1'b1;
                    bus.ifid_stall  = 1'b1;
                    bus.pipe_freeze = 1'b1;
                    bus.halted      = 1'b1;
                end
                default: begin
                    bus.pc_stall    = 1'b0;
                end
            endcase
        end
    end

    // Counter outputs are forced to zero while reset is held.
    always_comb begin
        bus.stall_cnt = rst ? 16'h0000 : stall_q;
        bus.flush_cnt = rst ? 16'h0000 : flush_q;
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (stall_inc && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    // Saturating branch-flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= 16'h0000;
        end else if (flush_inc && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'h0001;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the control rules.
module tb_ex_hazard_ctrl;

    logic clk;
    logic rst;
    ex_hazard_ctrl_if bus ();

    ex_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nfail;

    // Model state: pipeline halted, a bubble was just inserted, raw counts.
    bit m_halt;
    bit m_bubbled;
    int m_stall;
    int m_flush;

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, halted}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_STALL  = 6'b110100;
    localparam logic [5:0] O_FLUSH  = 6'b001100;
    localparam logic [5:0] O_FREEZE = 6'b110010;
    localparam logic [5:0] O_HALTED = 6'b110011;

    function automatic logic [5:0] dut_outs();
        return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush,
                bus.idex_bubble, bus.pipe_freeze, bus.halted};
    endfunction

    function automatic bit m_hazard();
        bit rs;
        bit rt;
        rs = bus.id_rs_valid && (bus.id_rs == bus.ex_rd);
        rt = bus.id_rt_valid && (bus.id_rt == bus.ex_rd);
        return bus.ex_valid && bus.ex_mem_read && (rs || rt);
    endfunction

    function automatic logic [5:0] model_outs();
        if (rst) return O_IDLE;
        if (m_halt) return O_HALTED;
        if (bus.mem_busy) return O_FREEZE;
        if (m_bubbled) return O_IDLE;
        if (bus.ex_valid && bus.branch) return O_FLUSH;
        if (bus.ex_valid && bus.ex_halt) return O_STALL;
        if (m_hazard()) return O_STALL;
        return O_IDLE;
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [15:0] m_stall_cnt();
        return rst ? 16'h0000 : sat16(m_stall);
    endfunction

    function automatic logic [15:0] m_flush_cnt();
        return rst ? 16'h0000 : sat16(m_flush);
    endfunction

    // Advance the model by the rules, then the clock; inputs stay
    // stable across the edge because they only change at negedge.
    task automatic tick();
        if (rst) begin
            m_halt    = 1'b0;
            m_bubbled = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (bus.mem_busy) begin
            m_stall++;
        end else if (m_bubbled) begin
            m_bubbled = 1'b0;
        end else if (bus.ex_valid && bus.branch) begin
            m_flush++;
        end else if (bus.ex_valid && bus.ex_halt) begin
            m_halt = 1'b1;
        end else if (m_hazard()) begin
            m_stall++;
            m_bubbled = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs       = 3'd0;
        bus.id_rs_valid = 1'b0;
        bus.id_rt       = 3'd0;
        bus.id_rt_valid = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = 3'd0;
        bus.branch      = 1'b0;
        bus.ex_halt     = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic load_use_inputs();
        idle_inputs();
        bus.ex_valid    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 3'd3;
        bus.id_rs       = 3'd3;
        bus.id_rs_valid = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ex_valid = 1'b1;
        bus.ex_halt  = 1'b1;
        bus.mem_busy = 1'b1;
        rst = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_IDLE) begin
            nfail++;
            $display("FAIL reset_outs: got %b want %b", dut_outs(), O_IDLE);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        nvec++;
        if (dut_outs() !== O_IDLE || bus.stall_cnt !== 16'd0 ||
            bus.flush_cnt !== 16'd0) begin
            nfail++;
            $display("FAIL reset_state: got %b/%h/%h want 000000/0000/0000",
                     dut_outs(), bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_inputs();
        #1;
        nvec++;
        if (dut_outs() !== O_STALL) begin
            nfail++;
            $display("FAIL lu_stall: got %b want %b", dut_outs(), O_STALL);
        end
        tick();
        nvec++;
        if (dut_outs() !== O_IDLE || bus.stall_cnt !== 16'd1) begin
            nfail++;
            $display("FAIL lu_bubble_once: got %b cnt %h want %b cnt 0001",
                     dut_outs(), bus.stall_cnt, O_IDLE);
        end
        idle_inputs();
        tick();
        bus.ex_valid    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 3'd0;
        bus.id_rt       = 3'd0;
        bus.id_rt_valid = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_STALL) begin
            nfail++;
            $display("FAIL lu_rt_r0: got %b want %b", dut_outs(), O_STALL);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        load_use_inputs();
        bus.branch = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_FLUSH) begin
            nfail++;
            $display("FAIL br_haz_outs: got %b want %b", dut_outs(), O_FLUSH);
        end
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd0 ||
            dut_outs() !== O_IDLE) begin
            nfail++;
            $display("FAIL br_haz_cnt: got f=%h s=%h o=%b want 0001/0000/0",
                     bus.flush_cnt, bus.stall_cnt, dut_outs());
        end
    endtask

    task automatic test_busy_bubble();
        do_reset();
        load_use_inputs();
        tick();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            nvec++;
            if (dut_outs() !== O_FREEZE) begin
                nfail++;
                $display("FAIL busy_bubble_c%0d: got %b want %b",
                         i, dut_outs(), O_FREEZE);
            end
            tick();
        end
        bus.mem_busy = 1'b0;
        #1;
        nvec++;
        if (dut_outs() !== O_IDLE || bus.stall_cnt !== 16'd6) begin
            nfail++;
            $display("FAIL busy_bubble_exit: got %b cnt %h want 000000 cnt 0006",
                     dut_outs(), bus.stall_cnt);
        end
        tick();
        nvec++;
        if (dut_outs() !== O_STALL) begin
            nfail++;
            $display("FAIL busy_bubble_run: got %b want %b", dut_outs(), O_STALL);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_halt();
        logic [15:0] sc;
        logic [15:0] fc;
        do_reset();
        bus.ex_valid = 1'b1;
        bus.ex_halt  = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_STALL) begin
            nfail++;
            $display("FAIL halt_req: got %b want %b", dut_outs(), O_STALL);
        end
        tick();
        sc = bus.stall_cnt;
        fc = bus.flush_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.branch   = 1'($urandom_range(0, 1));
            bus.mem_busy = 1'($urandom_range(0, 1));
            bus.ex_halt  = 1'($urandom_range(0, 1));
            #1;
            nvec++;
            if (dut_outs() !== O_HALTED || bus.stall_cnt !== sc ||
                bus.flush_cnt !== fc) begin
                nfail++;
                $display("FAIL halted_c%0d: got %b s=%h f=%h want %b s=%h f=%h",
                         i, dut_outs(), bus.stall_cnt, bus.flush_cnt,
                         O_HALTED, sc, fc);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_IDLE) begin
            nfail++;
            $display("FAIL halt_rst_comb: got %b want %b", dut_outs(), O_IDLE);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        nvec++;
        if (bus.halted !== 1'b0 || dut_outs() !== O_IDLE) begin
            nfail++;
            $display("FAIL halt_rst_exit: got %b want %b", dut_outs(), O_IDLE);
        end
    endtask

    task automatic test_non_hazard();
        do_reset();
        bus.ex_valid    = 1'b1;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 3'd2;
        bus.id_rs       = 3'd2;
        bus.id_rs_valid = 1'b0;
        bus.id_rt       = 3'd5;
        bus.id_rt_valid = 1'b1;
        #1;
        nvec++;
        if (dut_outs() !== O_IDLE) begin
            nfail++;
            $display("FAIL non_hazard: got %b want %b", dut_outs(), O_IDLE);
        end
        tick();
        nvec++;
        if (bus.stall_cnt !== 16'd0) begin
            nfail++;
            $display("FAIL non_hazard_cnt: got %h want 0000", bus.stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.id_rs       = 3'($urandom_range(0, 3));
            bus.id_rs_valid = 1'($urandom_range(0, 1));
            bus.id_rt       = 3'($urandom_range(0, 3));
            bus.id_rt_valid = 1'($urandom_range(0, 1));
            bus.ex_valid    = ($urandom_range(0, 9) != 0);
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_rd       = 3'($urandom_range(0, 3));
            bus.branch      = ($urandom_range(0, 7) == 0);
            bus.ex_halt     = ($urandom_range(0, 59) == 0);
            bus.mem_busy    = ($urandom_range(0, 9) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            #1;
            nvec++;
            if (dut_outs() !== model_outs() ||
                bus.stall_cnt !== m_stall_cnt() ||
                bus.flush_cnt !== m_flush_cnt()) begin
                nfail++;
                $display("FAIL rand_c%0d: got %b s=%h f=%h want %b s=%h f=%h",
                         i, dut_outs(), bus.stall_cnt, bus.flush_cnt,
                         model_outs(), m_stall_cnt(), m_flush_cnt());
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.mem_busy = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 65534 || i == 65535 || i == 70000) begin
                nvec++;
                if (bus.stall_cnt !== m_stall_cnt()) begin
                    nfail++;
                    $display("FAIL sat_c%0d: got %h want %h",
                             i, bus.stall_cnt, m_stall_cnt());
                end
            end
        end
        nvec++;
        if (bus.stall_cnt !== 16'hFFFF || dut_outs() !== O_FREEZE) begin
            nfail++;
            $display("FAIL sat_hold: got %h/%b want ffff/%b",
                     bus.stall_cnt, dut_outs(), O_FREEZE);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        nvec      = 0;
        nfail     = 0;
        m_halt    = 1'b0;
        m_bubbled = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        rst       = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_busy_bubble();
        test_halt();
        test_non_hazard();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port id_rs, input, 3 bits: source register 1 of the instruction in decode.
REQ-004 SHALL have port id_rs_valid, input, 1 bit: decode instruction reads id_rs.
REQ-005 SHALL have port id_rt, input, 3 bits: source register 2 of the instruction in decode.
REQ-006 SHALL have port id_rt_valid, input, 1 bit: decode instruction reads id_rt.
REQ-007 SHALL have port ex_valid, input, 1 bit: execute stage holds a real instruction, not a bubble.
REQ-008 SHALL have port ex_mem_read, input, 1 bit: execute instruction is a load.
REQ-009 SHALL have port ex_rd, input, 3 bits: destination register of the execute instruction.
REQ-010 SHALL have port branch, input, 1 bit: taken-branch or jump resolved by execute this cycle.
REQ-011 SHALL have port ex_halt, input, 1 bit: execute instruction is HALT.
REQ-012 SHALL have port mem_busy, input, 1 bit: data memory not ready; the whole pipe must freeze.
REQ-013 SHALL have port pc_stall, output, 1 bit: hold PC.
REQ-014 SHALL have port ifid_stall, output, 1 bit: hold IF/ID register.
REQ-015 SHALL have port ifid_flush, output, 1 bit: load NOP into IF/ID.
REQ-016 SHALL have port idex_bubble, output, 1 bit: load bubble (valid=0) into ID/EX.
REQ-017 SHALL have port pipe_freeze, output, 1 bit: hold ID/EX, EX/MEM and MEM/WB.
REQ-018 SHALL have port halted, output, 1 bit: processor halted.
REQ-019 SHALL have port stall_cnt, output, 16 bits: saturating count of stall cycles.
REQ-020 SHALL have port flush_cnt, output, 16 bits: saturating count of branch flushes.

Function
REQ-021 SHALL implement FSM states RUN, LU_BUBBLE, HALTED; encoding free.
REQ-022 SHALL compute outputs combinationally from the current state and inputs (Mealy); zero added latency.
REQ-023 SHALL define hazard as ex_valid & ex_mem_read & ((id_rs_valid & id_rs==ex_rd) | (id_rt_valid & id_rt==ex_rd)).
REQ-024 SHALL apply priority in RUN, highest first: mem_busy, branch (ex_valid & branch), halt (ex_valid & ex_halt), hazard.
REQ-025 SHALL, on mem_busy in RUN or LU_BUBBLE: assert pc_stall, ifid_stall, pipe_freeze; deassert flush/bubble; hold state; increment stall_cnt.
REQ-026 SHALL, on a taken branch (no mem_busy): assert ifid_flush and idex_bubble for that cycle only, no PC stall, increment flush_cnt, stay in RUN; a coincident hazard is ignored.
REQ-027 SHALL, on halt (no mem_busy, no branch): assert pc_stall, ifid_stall, idex_bubble; go to HALTED next cycle.
REQ-028 SHALL, on hazard only: assert pc_stall, ifid_stall, idex_bubble for one cycle; go to LU_BUBBLE; increment stall_cnt.
REQ-029 SHALL, in LU_BUBBLE without mem_busy: mask hazard detection, assert no stall/flush output, return to RUN next cycle; so each load-use inserts exactly one bubble.
REQ-030 SHALL, in HALTED: assert halted, pc_stall, ifid_stall, pipe_freeze continuously, ignore all inputs, leave only on rst; counters do not increment.
REQ-031 SHALL saturate stall_cnt and flush_cnt at 0xFFFF (no wrap).
REQ-032 SHALL treat register number 0 like any other register (no R0 exemption).

Reset
REQ-033 SHALL, while rst=1, force every output to 0 combinationally and, at the clock edge, set state=RUN and both counters to 0.
REQ-034 SHALL let rst override every input in every state, including HALTED and mid-mem_busy freeze.

Verification
REQ-035 SHALL cover load-use: ex_valid=1, ex_mem_read=1, ex_rd=3, id_rs=3, id_rs_valid=1 -> pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle, then 0 with inputs held; stall_cnt=1.
REQ-036 SHALL cover branch+hazard same cycle: hazard inputs as above, branch=1 -> ifid_flush=idex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt=0.
REQ-037 SHALL cover mem_busy for 5 cycles during LU_BUBBLE -> pc_stall=pipe_freeze=1 for 5 cycles, state held, then one idle cycle back to RUN; stall_cnt=6.
REQ-038 SHALL cover halt: ex_valid=1, ex_halt=1 -> halted=1 from next cycle onward despite branch/mem_busy toggling; rst=1 -> all outputs 0, halted=0 after edge.
REQ-039 SHALL cover saturation: 70000 mem_busy cycles -> stall_cnt=0xFFFF and stays there.
REQ-040 SHALL cover non-hazard: ex_mem_read=1, ex_rd=2, id_rs=2, id_rs_valid=0 -> no stall.
